// File: rtl/conv_pkg.sv
// Shared widths, saturation helper and pipeline control bundle
// for the multi-channel convolution MAC.
package conv_pkg;

  typedef struct packed {
    logic valid;
    logic last;
    logic relu;
  } pctl_t;

  function automatic int calc_p_w(input int img_w, input int wgt_w);
    return img_w + wgt_w + 1;
  endfunction

  function automatic int calc_sum_w(
    input int img_w,
    input int wgt_w,
    input int taps
  );
    return calc_p_w(img_w, wgt_w) + $clog2(taps);
  endfunction

  // Clamp x into the signed range of an acc_w-bit word.
  function automatic logic signed [63:0] sat_clamp(
    input logic signed [63:0] x,
    input int                 acc_w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/conv_mac_pipe_if.sv
// Beat input and group result handshakes of the convolution MAC.
// master drives beats and out_ready, slave is the MAC.
interface conv_mac_pipe_if #(
  parameter int K_H   = 3,
  parameter int K_W   = 3,
  parameter int IMG_W = 8,
  parameter int WGT_W = 8,
  parameter int ACC_W = 24,
  parameter int N_CH  = 4
) ();
  localparam int CW = $clog2(N_CH + 1);

  logic                                  in_valid;
  logic                                  in_ready;
  logic                                  in_last;
  logic                                  relu_en;
  logic [K_H-1:0][K_W-1:0][IMG_W-1:0]    img;
  logic [K_H-1:0][K_W-1:0][WGT_W-1:0]    w;
  logic                                  out_valid;
  logic                                  out_ready;
  logic signed [ACC_W-1:0]               result;
  logic                                  sat;
  logic [CW-1:0]                         ch_cnt;

  modport master (
    output in_valid, in_last, relu_en, img, w, out_ready,
    input  in_ready, out_valid, result, sat, ch_cnt
  );

  modport slave (
    input  in_valid, in_last, relu_en, img, w, out_ready,
    output in_ready, out_valid, result, sat, ch_cnt
  );
endinterface

// File: rtl/conv_adder_tree.sv
// Registered signed reduction of N taps, one cycle latency,
// holding its output while the pipeline is stalled.
module conv_adder_tree #(
  parameter int N     = 9,
  parameter int IN_W  = 17,
  parameter int OUT_W = 21
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_en,
  input  logic [N-1:0][IN_W-1:0]   i_d,
  output logic signed [OUT_W-1:0]  o_sum
);
  logic signed [OUT_W-1:0] w_sum;
  logic signed [OUT_W-1:0] r_sum;

  // Sign-extend every tap and add them up
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N; i++) begin
      w_sum = w_sum + OUT_W'($signed(i_d[i]));
    end
  end

  // Register the reduced sum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sum <= '0;
    else if (i_en) r_sum <= w_sum;
  end

  assign o_sum = r_sum;
endmodule

// File: rtl/conv_mac_pipe.sv
// Three-stage K_H x K_W MAC: products, adder tree, channel
// accumulate with saturation, optional ReLU and group output.
module conv_mac_pipe #(
  parameter int K_H   = 3,
  parameter int K_W   = 3,
  parameter int IMG_W = 8,
  parameter int WGT_W = 8,
  parameter int ACC_W = 24,
  parameter int N_CH  = 4
) (
  input logic             clk,
  input logic             rst,
  conv_mac_pipe_if.slave  bus
);
  import conv_pkg::*;

  localparam int NT    = K_H * K_W;
  localparam int P_W   = calc_p_w(IMG_W, WGT_W);
  localparam int SUM_W = calc_sum_w(IMG_W, WGT_W, NT);
  localparam int CW    = $clog2(N_CH + 1);

  logic                    w_en;
  logic                    w_acc;
  logic                    w_s1_last;
  logic [NT-1:0][P_W-1:0]  w_prod;
  logic [NT-1:0][P_W-1:0]  r_prod;
  logic [CW-1:0]           r_cnt;
  pctl_t                   r_s1;
  pctl_t                   r_s2;
  logic signed [SUM_W-1:0] w_sum;

  logic signed [ACC_W:0]   w_base;
  logic signed [ACC_W:0]   w_nxt;
  logic signed [63:0]      w_c64;
  logic signed [ACC_W-1:0] w_clamped;
  logic                    w_ovf;
  logic                    w_load;

  logic signed [ACC_W-1:0] r_acc;
  logic                    r_first;
  logic                    r_sat_st;
  logic [CW-1:0]           r_gcnt;
  logic                    r_out_valid;
  logic signed [ACC_W-1:0] r_result;
  logic                    r_sat;
  logic [CW-1:0]           r_ch_cnt;

  assign w_en      = !(r_out_valid && !bus.out_ready);
  assign w_acc     = bus.in_valid && w_en;
  assign w_s1_last = bus.in_last || (r_cnt == CW'(N_CH - 1));

  // Per-tap products of zero-extended pixel and signed weight
  always_comb begin
    w_prod = '0;
    for (int h = 0; h < K_H; h++) begin
      for (int c = 0; c < K_W; c++) begin
        w_prod[h*K_W+c] =
          P_W'($signed({1'b0, bus.img[h][c]})) *
          P_W'($signed(bus.w[h][c]));
      end
    end
  end

  // S1: capture products and group control, count beats
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1   <= '0;
      r_prod <= '0;
      r_cnt  <= '0;
    end else if (w_en) begin
      r_s1.valid <= w_acc;
      r_s1.last  <= w_s1_last;
      r_s1.relu  <= bus.relu_en;
      if (w_acc) begin
        r_prod <= w_prod;
        r_cnt  <= w_s1_last ? '0 : r_cnt + 1'b1;
      end
    end
  end

  conv_adder_tree #(
    .N     (NT),
    .IN_W  (P_W),
    .OUT_W (SUM_W)
  ) u_tree (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_en),
    .i_d   (r_prod),
    .o_sum (w_sum)
  );

  // S2: control travels alongside the adder tree
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_s2 <= '0;
    else if (w_en) r_s2 <= r_s1;
  end

  // Accumulate in one extra bit, then clamp to ACC_W
  always_comb begin
    w_base    = r_first ? '0 : (ACC_W+1)'(r_acc);
    w_nxt     = w_base + (ACC_W+1)'(w_sum);
    w_c64     = sat_clamp(64'(w_nxt), ACC_W);
    w_clamped = w_c64[ACC_W-1:0];
    w_ovf     = (w_c64 != 64'(w_nxt));
    w_load    = w_en && r_s2.valid && r_s2.last;
  end

  // S3: channel accumulator and group output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_first     <= 1'b1;
      r_sat_st    <= 1'b0;
      r_gcnt      <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_sat       <= 1'b0;
      r_ch_cnt    <= '0;
    end else begin
      if (w_en && r_s2.valid) begin
        if (r_s2.last) begin
          r_result <= (r_s2.relu && w_clamped < 0) ? '0 : w_clamped;
          r_sat    <= r_sat_st | w_ovf;
          r_ch_cnt <= r_gcnt + 1'b1;
          r_acc    <= '0;
          r_sat_st <= 1'b0;
          r_first  <= 1'b1;
          r_gcnt   <= '0;
        end else begin
          r_acc    <= w_clamped;
          r_sat_st <= r_sat_st | w_ovf;
          r_first  <= 1'b0;
          r_gcnt   <= r_gcnt + 1'b1;
        end
      end
      if (w_load) r_out_valid <= 1'b1;
      else if (r_out_valid && bus.out_ready) r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_en;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.sat       = r_sat;
  assign bus.ch_cnt    = r_ch_cnt;
endmodule

// File: tb/tb_conv_mac_pipe.sv
// Bench for conv_mac_pipe: group-level model with saturation,
// two instances (ACC_W 24 and 20) driven by the same beats.
module tb_conv_mac_pipe;
  localparam int KH  = 3;
  localparam int KW  = 3;
  localparam int IW  = 8;
  localparam int WW  = 8;
  localparam int AW  = 24;
  localparam int AWB = 20;
  localparam int NC  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  conv_mac_pipe_if #(.K_H(KH), .K_W(KW), .IMG_W(IW), .WGT_W(WW),
                     .ACC_W(AW), .N_CH(NC)) bA ();
  conv_mac_pipe_if #(.K_H(KH), .K_W(KW), .IMG_W(IW), .WGT_W(WW),
                     .ACC_W(AWB), .N_CH(NC)) bB ();

  assign bB.in_valid  = bA.in_valid;
  assign bB.in_last   = bA.in_last;
  assign bB.relu_en   = bA.relu_en;
  assign bB.img       = bA.img;
  assign bB.w         = bA.w;
  assign bB.out_ready = bA.out_ready;

  conv_mac_pipe #(.K_H(KH), .K_W(KW), .IMG_W(IW), .WGT_W(WW),
                  .ACC_W(AW), .N_CH(NC)) dA (
    .clk (clk), .rst (rst), .bus (bA.slave));
  conv_mac_pipe #(.K_H(KH), .K_W(KW), .IMG_W(IW), .WGT_W(WW),
                  .ACC_W(AWB), .N_CH(NC)) dB (
    .clk (clk), .rst (rst), .bus (bB.slave));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    longint resA;
    bit     satA;
    longint resB;
    bit     satB;
    int     cnt;
  } exp_t;

  exp_t   expq[$];
  longint obsA[$];
  bit     obs_satA[$];
  longint obsB[$];
  bit     obs_satB[$];
  int     obs_cnt[$];

  longint m_accA, m_accB;
  bit     m_satA, m_satB;
  int     m_cnt;
  exp_t   m_e;

  function automatic longint clampw(input longint x, input int aw);
    longint hi, lo;
    hi = (longint'(1) <<< (aw - 1)) - 1;
    lo = -hi - 1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  task automatic model_clear();
    m_accA = 0; m_accB = 0;
    m_satA = 0; m_satB = 0;
    m_cnt  = 0;
  endtask

  task automatic model_beat();
    longint s, nA, nB, cA, cB;
    exp_t   e;
    s = 0;
    for (int h = 0; h < KH; h++)
      for (int c = 0; c < KW; c++)
        s += longint'(bA.img[h][c]) * longint'($signed(bA.w[h][c]));
    m_cnt++;
    nA = m_accA + s; cA = clampw(nA, AW);
    nB = m_accB + s; cB = clampw(nB, AWB);
    m_satA |= (cA != nA); m_accA = cA;
    m_satB |= (cB != nB); m_accB = cB;
    if (bA.in_last || m_cnt == NC) begin
      e.resA = (bA.relu_en && cA < 0) ? 0 : cA;
      e.resB = (bA.relu_en && cB < 0) ? 0 : cB;
      e.satA = m_satA;
      e.satB = m_satB;
      e.cnt  = m_cnt;
      expq.push_back(e);
      model_clear();
    end
  endtask

  // Compare process: handshake rule and every emitted group
  always @(negedge clk) begin
    if (rst) begin
      model_clear();
      expq.delete();
    end else begin
      chk("in_ready_rule", bA.in_ready,
          !(bA.out_valid && !bA.out_ready));
      if (bA.out_valid && bA.out_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          m_e = expq.pop_front();
          chk("resA", bA.result, m_e.resA);
          chk("satA", bA.sat, m_e.satA);
          chk("cntA", bA.ch_cnt, m_e.cnt);
          chk("validB", bB.out_valid, 1);
          chk("resB", bB.result, m_e.resB);
          chk("satB", bB.sat, m_e.satB);
          chk("cntB", bB.ch_cnt, m_e.cnt);
        end
        obsA.push_back(bA.result);
        obs_satA.push_back(bA.sat);
        obsB.push_back(bB.result);
        obs_satB.push_back(bB.sat);
        obs_cnt.push_back(int'(bA.ch_cnt));
      end
      if (bA.in_valid && bA.in_ready) model_beat();
    end
  end

  task automatic set_win(input int iv, input int wv);
    for (int h = 0; h < KH; h++)
      for (int c = 0; c < KW; c++) begin
        bA.img[h][c] = 8'(iv);
        bA.w[h][c]   = 8'(wv);
      end
  endtask

  task automatic send(input int iv, input int wv,
                      input bit last, input bit relu);
    int k;
    set_win(iv, wv);
    bA.in_last  = last;
    bA.relu_en  = relu;
    bA.in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!bA.in_ready && k < 200) begin
      k++;
      @(negedge clk);
    end
    if (k >= 200) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    bA.in_valid = 1'b0;
    bA.in_last  = 1'b0;
    bA.relu_en  = 1'b0;
  endtask

  task automatic wait_outs(input int target, input int budget);
    int k;
    k = 0;
    while (obs_cnt.size() < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (obs_cnt.size() < target)
      chk("wait_out_timeout", obs_cnt.size(), target);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  int  st;
  int  k;
  bit  acc;

  initial begin
    bA.in_valid  = 1'b0;
    bA.in_last   = 1'b0;
    bA.relu_en   = 1'b0;
    bA.out_ready = 1'b1;
    set_win(0, 0);
    model_clear();
    #2 rst = 1'b1;
    #1;
    chk("rst_validA", bA.out_valid, 0);
    chk("rst_resA", bA.result, 0);
    chk("rst_satA", bA.sat, 0);
    chk("rst_cntA", bA.ch_cnt, 0);
    chk("rst_validB", bB.out_valid, 0);
    chk("rst_resB", bB.result, 0);
    chk("rst_ready", bA.in_ready, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single beat, latency t+3
    st = obs_cnt.size();
    set_win(1, 1);
    bA.in_last  = 1'b1;
    bA.in_valid = 1'b1;
    @(negedge clk);
    chk("lat_accept", bA.in_ready, 1);
    @(posedge clk); #1;
    bA.in_valid = 1'b0;
    bA.in_last  = 1'b0;
    @(negedge clk); chk("lat_t1", bA.out_valid, 0);
    @(negedge clk); chk("lat_t2", bA.out_valid, 0);
    @(negedge clk); chk("lat_t3", bA.out_valid, 1);
    wait_outs(st + 1, 20);
    chk("one_res", obsA[st], 9);
    chk("one_sat", obs_satA[st], 0);
    chk("one_cnt", obs_cnt[st], 1);

    // Four strongly negative channels
    st = obs_cnt.size();
    repeat (3) send(255, -128, 0, 0);
    send(255, -128, 1, 0);
    wait_outs(st + 1, 30);
    chk("neg_resA", obsA[st], -1175040);
    chk("neg_satA", obs_satA[st], 0);
    chk("neg_cnt", obs_cnt[st], 4);
    chk("neg_resB", obsB[st], -524288);
    chk("neg_satB", obs_satB[st], 1);

    // Same with ReLU on the final beat
    st = obs_cnt.size();
    repeat (3) send(255, -128, 0, 0);
    send(255, -128, 1, 1);
    wait_outs(st + 1, 30);
    chk("relu_resA", obsA[st], 0);
    chk("relu_satA", obs_satA[st], 0);
    chk("relu_resB", obsB[st], 0);
    chk("relu_satB", obs_satB[st], 1);

    // Auto-terminate at N_CH beats
    st = obs_cnt.size();
    repeat (4) send(2, 1, 0, 0);
    send(2, 1, 1, 0);
    wait_outs(st + 2, 30);
    chk("auto_res0", obsA[st], 72);
    chk("auto_cnt0", obs_cnt[st], 4);
    chk("auto_res1", obsA[st+1], 18);
    chk("auto_cnt1", obs_cnt[st+1], 1);

    // Backpressure: hold result, block input
    st = obs_cnt.size();
    bA.out_ready = 1'b0;
    send(1, 1, 1, 0);
    send(2, 1, 1, 0);
    send(3, 1, 1, 0);
    k = 0;
    while (!bA.out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("bp_valid_seen", bA.out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_in_ready", bA.in_ready, 0);
      chk("bp_valid", bA.out_valid, 1);
      chk("bp_result", bA.result, 9);
    end
    @(posedge clk); #1;
    bA.out_ready = 1'b1;
    send(4, 1, 1, 0);
    wait_outs(st + 4, 30);
    repeat (10) @(posedge clk);
    #1;
    chk("bp_count", obs_cnt.size() - st, 4);
    chk("bp_r0", obsA[st], 9);
    chk("bp_r1", obsA[st+1], 18);
    chk("bp_r2", obsA[st+2], 27);
    chk("bp_r3", obsA[st+3], 36);

    // Reset in the middle of a group
    send(1, 1, 0, 0);
    send(1, 1, 0, 0);
    rst = 1'b1;
    #1;
    chk("mrst_validA", bA.out_valid, 0);
    chk("mrst_resA", bA.result, 0);
    chk("mrst_satA", bA.sat, 0);
    chk("mrst_cntA", bA.ch_cnt, 0);
    chk("mrst_resB", bB.result, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    st = obs_cnt.size();
    send(1, 1, 1, 0);
    wait_outs(st + 1, 20);
    chk("mrst_res", obsA[st], 9);
    chk("mrst_cnt", obs_cnt[st], 1);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      acc = bA.in_valid && bA.in_ready;
      @(posedge clk); #1;
      bA.out_ready = ($urandom % 10) < 7;
      if (!bA.in_valid || acc) begin
        if (($urandom % 10) < 7) begin
          for (int h = 0; h < KH; h++)
            for (int c = 0; c < KW; c++) begin
              bA.img[h][c] = 8'($urandom);
              bA.w[h][c]   = 8'($urandom);
            end
          bA.in_last  = ($urandom % 10) < 3;
          bA.relu_en  = $urandom % 2;
          bA.in_valid = 1'b1;
        end else begin
          bA.in_valid = 1'b0;
        end
      end
    end
    @(negedge clk);
    @(posedge clk); #1;
    bA.in_valid  = 1'b0;
    bA.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("drain_empty", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_mac_pipe.md
Name: conv_mac_pipe

Overview:
- Pipelined multi-channel K_H x K_W convolution MAC, the next generation of the single-cycle window MAC in the NPU datapath.
- Each accepted beat is one input channel's window and kernel. The block multiplies, reduces through an adder tree, and accumulates across up to N_CH channels.
- Each finished group is emitted through a valid/ready output, with optional ReLU and saturation.
- Sits between the line-buffer/window generator and the NPU requant/writeback stage.

Parameters:
- K_H, 3, kernel height
- K_W, 3, kernel width
- IMG_W, 8, unsigned pixel width
- WGT_W, 8, signed weight width
- ACC_W, 24, signed accumulator/result width; must be >= SUM_W (below)
- N_CH, 4, maximum channels per output group; must be >= 1

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_last  in  1  last channel of the current group
- relu_en  in  1  apply ReLU to the group result; sampled with the group's final beat
- img  in  [K_H][K_W] x IMG_W  unsigned window
- w  in  [K_H][K_W] x WGT_W  signed kernel
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- result  out  ACC_W signed  group sum
- sat  out  1  result was clamped in this group
- ch_cnt  out  clog2(N_CH+1)  number of beats in the emitted group

Behaviour:
- Reset is asynchronous and active-high; the design has one clock, clk.
- Reset state: all pipeline valids 0, accumulator 0, channel counter 0, out_valid 0, result 0, sat 0, ch_cnt 0.
- Width rules:
  - P_W = IMG_W+WGT_W+1.
  - img is zero-extended to signed.
  - SUM_W = P_W + clog2(K_H*K_W), default 21.
  - The sum is sign-extended to ACC_W+1 for accumulation.
- Global enable: en = !(out_valid && !out_ready). in_ready = en, which is combinational from out_valid/out_ready. All stages advance only when en; on stall every register holds.
- Stage S1, on accept:
  - Register the K_H*K_W products, v1, last1, relu1.
  - last1 = in_last || (cnt == N_CH-1), i.e. auto-terminate at N_CH beats.
  - The beat counter increments on accept and clears on a last beat.
- Stage S2: registered adder-tree sum, v2, last2, relu2.
- Stage S3, on v2:
  - nxt = (first ? 0 : acc) + sum, computed in ACC_W+1 bits.
  - Clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; OR the clamp event into a sticky group-sat bit.
  - The first flag is set after reset and after each last2.
  - If last2, load the output registers with result = (relu2 && clamped<0) ? 0 : clamped, sat = sticky, ch_cnt = beats in the group. Set out_valid=1, and clear the accumulator and sticky bit.
  - Otherwise acc <= clamped.
- Output holds result, sat and ch_cnt stable while out_valid && !out_ready. out_valid drops on handshake unless S3 loads a new result in the same cycle.
- Latency: the last beat is accepted at cycle t; out_valid is 1 at t+3 with no stall. Throughput is one beat per cycle.
- Boundary cases:
  - With in_last=1 on every beat, every beat is its own group.
  - An in_valid bubble between channels is allowed; the accumulator holds.
  - With N_CH=1, every beat is last.
  - Reset mid-group discards all partial state; no output is produced for that group.

Decomposition:
- Package conv_pkg holds P_W/SUM_W computation functions, the saturate function, and a typedef for the S1/S2 pipeline control struct (valid, last, relu).
- One sub-module, conv_adder_tree: registered K_H*K_W-input signed reduction with enable, latency 1.

Test Plan:
- Single beat, img all 1, w all 1, in_last=1, relu_en=0 -> out_valid at t+3, result=9, sat=0, ch_cnt=1.
- Four beats, img all 255, w all -128, in_last on the 4th -> result=-1175040, sat=0, ch_cnt=4. Repeat with relu_en=1 on the 4th beat -> result=0.
- ACC_W=20, same four beats -> result=-524288, sat=1.
- Five beats, w all 1, img all 2, no in_last -> two results: first 72 with ch_cnt=4 (auto-terminate), second 18 with ch_cnt=1 after in_last on beat 5.
- Backpressure: out_ready=0 while a result is valid -> in_ready=0, result stable for 5 cycles. Release -> handshake, next group follows with no lost or duplicated beats.
- Assert rst after 2 beats of a 4-beat group -> all outputs 0 immediately. A following fresh 1-beat group (img 1, w 1) -> result=9.
